// File: rtl/pcg_pkg.sv
// Shared types and constants for the PCG32 generator and bounded sampler.
// Holds the sampler FSM encoding and the generator's LCG constants.
package pcg_pkg;

  localparam int W_DEF     = 32;
  localparam int CNT_W_DEF = 16;

  localparam logic [W_DEF-1:0]     W_ONES  = '1;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  localparam logic [63:0] PCG_MULT = 64'h5851_f42d_4c95_7f2d;
  localparam logic [63:0] PCG_INC  = 64'h1405_7b7e_f767_814f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_THRESH,
    S_DRAW,
    S_CHECK,
    S_OUT
  } state_t;

endpackage

// File: rtl/pcg_serial_divider.sv
// Bit-serial restoring divider, one quotient bit per cycle, W cycles.
// Only the remainder is kept; done is high during the final step.
module pcg_serial_divider
  import pcg_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  dq;
  logic [W-1:0]  dv;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          fits;

  // diff never underflows past bit W because trial < 2*divisor
  assign trial     = {rem, dq[W-1]};
  assign diff      = trial - {1'b0, dv};
  assign fits      = ~diff[W];
  assign remainder = fits ? diff[W-1:0] : trial[W-1:0];
  assign done      = busy && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq   <= '0;
      dv   <= '0;
      rem  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      dq   <= dividend;
      dv   <= divisor;
      rem  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= remainder;
      dq  <= dq << 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pcg_bounded_sampler.sv
// Unbiased bounded sampler: Lemire multiply-and-reject over PCG32 words.
// The rejection threshold is computed serially and cached per bound.
module pcg_bounded_sampler
  import pcg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_bound,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [W-1:0]     rnd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_value,
  output logic [CNT_W-1:0] rej_count
);

  state_t state;
  state_t nxt_state;

  logic [W-1:0]   b;
  logic [W-1:0]   cached;
  logic [W-1:0]   thr;
  logic           thr_valid;
  logic           pass;
  logic [2*W-1:0] m;

  logic         req_hs;
  logic         rnd_hs;
  logic         hit;
  logic         need_thr;
  logic         reject;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_rem;

  assign req_hs   = req_valid & req_ready;
  assign rnd_hs   = rnd_valid & rnd_ready;
  assign hit      = thr_valid && (req_bound == cached);
  assign need_thr = (req_bound != '0) && !hit;
  assign reject   = m[W-1:0] < thr;

  pcg_serial_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  ('0 - req_bound),
    .divisor   (req_bound),
    .busy      (div_busy),
    .done      (div_done),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      S_IDLE:   if (req_hs) nxt_state = need_thr ? S_THRESH : S_DRAW;
      S_THRESH: begin
        if (div_done)      nxt_state = S_DRAW;
        else if (!div_busy) nxt_state = S_IDLE;
      end
      S_DRAW:   if (rnd_hs) nxt_state = pass ? S_OUT : S_CHECK;
      S_CHECK:  nxt_state = reject ? S_DRAW : S_OUT;
      S_OUT:    if (out_ready) nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // req_ready is masked by rst so it reads 0 during the reset cycle
  always_comb begin
    req_ready = (state == S_IDLE) && !rst;
    rnd_ready = (state == S_DRAW);
    out_valid = (state == S_OUT);
    div_start = req_ready && req_valid && need_thr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b         <= '0;
      cached    <= '0;
      thr       <= '0;
      thr_valid <= 1'b0;
      pass      <= 1'b0;
      m         <= '0;
      out_value <= '0;
      rej_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req_hs) begin
          b    <= req_bound;
          pass <= (req_bound == '0);
        end
        S_THRESH: if (div_done) begin
          thr       <= div_rem;
          cached    <= b;
          thr_valid <= 1'b1;
        end
        S_DRAW: if (rnd_hs) begin
          if (pass) out_value <= rnd_data;
          else      m <= (2*W)'(rnd_data) * (2*W)'(b);
        end
        S_CHECK: begin
          if (!reject)               out_value <= m[2*W-1:W];
          else if (rej_count != '1)  rej_count <= rej_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
